// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings and default latencies.
package mdu_pkg;

  localparam int MDU_OP_W    = 3;
  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_NONE = 3'd0,
    MULT     = 3'd1,
    MULTU    = 3'd2,
    DIV      = 3'd3,
    DIVU     = 3'd4,
    MTHI     = 3'd5,
    MTLO     = 3'd6
  } mdu_op_e;

endpackage

// File: rtl/mdu_if.sv
// Issue/result bundle between the EX stage control and the multiply/divide unit.
interface mdu_if;
  import mdu_pkg::*;

  logic                start;
  logic [MDU_OP_W-1:0] op;
  logic                flush;
  logic [31:0]         rs;
  logic [31:0]         rt;
  logic                busy;
  logic [31:0]         hi;
  logic [31:0]         lo;

  modport master (output start, op, flush, rs, rt, input busy, hi, lo);
  modport slave  (input start, op, flush, rs, rt, output busy, hi, lo);
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// The result is computed combinationally at issue and parked until the
// latency counter expires, so HI/LO only change when busy drops.
module mdu
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  // Signed divide returning {remainder, quotient}; the single overflowing
  // case is pinned explicitly, and a zero divisor yields zeros (never written).
  function automatic logic [63:0] sdivmod(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] q;
    logic signed [31:0] r;
    if (b == 32'd0) return 64'd0;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    q = $signed(a) / $signed(b);
    r = $signed(a) % $signed(b);
    return {r, q};
  endfunction

  // Unsigned divide returning {remainder, quotient}.
  function automatic logic [63:0] udivmod(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 64'd0;
    return {a % b, a / b};
  endfunction

  mdu_op_e            op_e;
  logic               issue;
  logic signed [63:0] prod_s_p0;
  logic        [63:0] prod_u_p0;
  logic        [63:0] sdiv_p0;
  logic        [63:0] udiv_p0;
  logic        [31:0] res_hi_p0;
  logic        [31:0] res_lo_p0;
  logic               res_wr_p0;
  logic               is_long_p0;
  logic   [CNT_W-1:0] lat_p0;

  logic               busy;
  logic   [CNT_W-1:0] cnt;
  logic        [31:0] hi;
  logic        [31:0] lo;
  logic        [31:0] pend_hi;
  logic        [31:0] pend_lo;
  logic               pend_wr;

  assign op_e  = mdu_op_e'(bus.op);
  assign issue = bus.start && !bus.flush && !busy;

  assign prod_s_p0 = $signed({{32{bus.rs[31]}}, bus.rs}) * $signed({{32{bus.rt[31]}}, bus.rt});
  assign prod_u_p0 = {32'd0, bus.rs} * {32'd0, bus.rt};
  assign sdiv_p0   = sdivmod(bus.rs, bus.rt);
  assign udiv_p0   = udivmod(bus.rs, bus.rt);

  // Select the parked result, its write enable and latency for the issuing op.
  always_comb begin
    res_hi_p0  = 32'd0;
    res_lo_p0  = 32'd0;
    res_wr_p0  = 1'b0;
    is_long_p0 = 1'b0;
    lat_p0     = '0;
    case (op_e)
      MULT: begin
        {res_hi_p0, res_lo_p0} = prod_s_p0;
        res_wr_p0  = 1'b1;
        is_long_p0 = 1'b1;
        lat_p0     = CNT_W'(MUL_LAT);
      end
      MULTU: begin
        {res_hi_p0, res_lo_p0} = prod_u_p0;
        res_wr_p0  = 1'b1;
        is_long_p0 = 1'b1;
        lat_p0     = CNT_W'(MUL_LAT);
      end
      DIV: begin
        {res_hi_p0, res_lo_p0} = sdiv_p0;
        res_wr_p0  = (bus.rt != 32'd0);
        is_long_p0 = 1'b1;
        lat_p0     = CNT_W'(DIV_LAT);
      end
      DIVU: begin
        {res_hi_p0, res_lo_p0} = udiv_p0;
        res_wr_p0  = (bus.rt != 32'd0);
        is_long_p0 = 1'b1;
        lat_p0     = CNT_W'(DIV_LAT);
      end
      default: ;
    endcase
  end

  // IDLE/BUSY sequencer (busy is the state): issue, count down, commit HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= 1'b0;
      cnt     <= '0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
    end else if (busy) begin
      if (cnt == CNT_W'(1)) begin
        if (pend_wr) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end else if (issue) begin
      if (is_long_p0) begin
        pend_hi <= res_hi_p0;
        pend_lo <= res_lo_p0;
        pend_wr <= res_wr_p0;
        cnt     <= lat_p0;
        busy    <= 1'b1;
      end else if (op_e == MTHI) begin
        hi <= bus.rs;
      end else if (op_e == MTLO) begin
        lo <= bus.rs;
      end
    end
  end

  assign bus.busy = busy;
  assign bus.hi   = hi;
  assign bus.lo   = lo;

endmodule

// File: tb/tb_mdu.sv
// Randomised and directed bench for mdu against a timeline-based reference model.
module tb_mdu;
  import mdu_pkg::*;

  localparam int ML = 5;
  localparam int DL = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_if bus();

  mdu #(.MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic from magnitudes and signs, independent of the RTL's operators.
  function automatic void model_calc(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] h, output logic [31:0] l, output bit wr);
    longint sa, sb, ua, ub, q, r;
    longint unsigned pu;
    longint ps;
    h = 32'd0; l = 32'd0; wr = 1'b1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd1: begin ps = sa * sb; h = ps[63:32]; l = ps[31:0]; end
      3'd2: begin pu = longint'({32'd0, a}) * longint'({32'd0, b}); h = pu[63:32]; l = pu[31:0]; end
      3'd3: begin
        if (b == 32'd0) wr = 1'b0;
        else begin
          ua = (sa < 0) ? -sa : sa;
          ub = (sb < 0) ? -sb : sb;
          q = ua / ub;
          r = ua % ub;
          if ((sa < 0) != (sb < 0)) q = -q;
          if (sa < 0) r = -r;
          h = r[31:0]; l = q[31:0];
        end
      end
      3'd4: begin
        if (b == 32'd0) wr = 1'b0;
        else begin
          ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
          q = ua / ub; r = ua % ub;
          h = r[31:0]; l = q[31:0];
        end
      end
      default: wr = 1'b0;
    endcase
  endfunction

  // Model state: edges counted; an op issued at edge T lands at edge T+LAT.
  int          cyc = 0;
  int          done_at = 0;
  bit          armed = 1'b0;
  bit          pend_act = 1'b0;
  bit          pend_ok;
  logic [31:0] pend_h, pend_l;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_hi = 32'd0; m_lo = 32'd0; done_at = 0; pend_act = 1'b0; armed = 1'b1;
    end else if (cyc <= done_at) begin
      if (cyc == done_at && pend_act) begin
        if (pend_ok) begin m_hi = pend_h; m_lo = pend_l; end
        pend_act = 1'b0;
      end
    end else if (bus.start && !bus.flush) begin
      case (bus.op)
        3'd1, 3'd2, 3'd3, 3'd4: begin
          model_calc(bus.op, bus.rs, bus.rt, pend_h, pend_l, pend_ok);
          pend_act = 1'b1;
          done_at  = cyc + ((bus.op <= 3'd2) ? ML : DL);
        end
        3'd5: m_hi = bus.rs;
        3'd6: m_lo = bus.rs;
        default: ;
      endcase
    end
  end

  // Every cycle after reset has been seen: outputs must match the model.
  always @(negedge clk) begin
    if (armed) begin
      chk("model_busy", {31'd0, bus.busy}, {31'd0, (cyc < done_at)});
      chk("model_hi", bus.hi, m_hi);
      chk("model_lo", bus.lo, m_lo);
    end
  end

  task automatic drive(input bit s, input logic [2:0] o, input bit f,
                       input logic [31:0] a, input logic [31:0] b);
    bus.start = s; bus.op = o; bus.flush = f; bus.rs = a; bus.rt = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] eh, input logic [31:0] el);
    drive(1'b1, o, 1'b0, a, b);
    for (int i = 0; i < lat; i++) begin
      chk({nm, "_busy"}, {31'd0, bus.busy}, 32'd1);
      idle(1);
    end
    chk({nm, "_done"}, {31'd0, bus.busy}, 32'd0);
    chk({nm, "_hi"}, bus.hi, eh);
    chk({nm, "_lo"}, bus.lo, el);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 3'd0; bus.flush = 1'b0; bus.rs = 32'd0; bus.rt = 32'd0;
    idle(2);
    reset = 1'b0;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);

    run_op("mult", 3'd1, 32'hFFFF_FFFD, 32'd5, ML, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, ML, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, DL, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", 3'd4, 32'd7, 32'd2, DL, 32'd1, 32'd3);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DL, 32'd0, 32'h8000_0000);

    drive(1'b1, 3'd5, 1'b0, 32'h11, 32'd0);
    chk("mthi_hi", bus.hi, 32'h11);
    chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
    drive(1'b1, 3'd6, 1'b0, 32'h22, 32'd0);
    chk("mtlo_lo", bus.lo, 32'h22);
    chk("mtlo_busy", {31'd0, bus.busy}, 32'd0);
    run_op("div0", 3'd4, 32'd7, 32'd0, DL, 32'h11, 32'h22);

    drive(1'b1, 3'd1, 1'b1, 32'd3, 32'd4);
    chk("flush_mult_busy", {31'd0, bus.busy}, 32'd0);
    idle(ML + 1);
    chk("flush_mult_hi", bus.hi, 32'h11);
    chk("flush_mult_lo", bus.lo, 32'h22);
    drive(1'b1, 3'd6, 1'b1, 32'h55, 32'd0);
    chk("flush_mtlo_lo", bus.lo, 32'h22);

    drive(1'b1, 3'd0, 1'b0, 32'h77, 32'h77);
    chk("none_busy", {31'd0, bus.busy}, 32'd0);
    chk("none_hi", bus.hi, 32'h11);

    drive(1'b1, 3'd1, 1'b0, 32'h0001_0000, 32'h0003_0000);
    drive(1'b1, 3'd5, 1'b0, 32'h99, 32'd0);
    chk("ign_hi_during", bus.hi, 32'h11);
    idle(ML - 1);
    chk("ign_busy", {31'd0, bus.busy}, 32'd0);
    chk("ign_hi", bus.hi, 32'd3);
    chk("ign_lo", bus.lo, 32'd0);

    drive(1'b1, 3'd3, 1'b0, 32'd100, 32'd7);
    idle(2);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("rmid_busy", {31'd0, bus.busy}, 32'd0);
    chk("rmid_hi", bus.hi, 32'd0);
    chk("rmid_lo", bus.lo, 32'd0);
    idle(DL + 2);
    chk("rmid_late_hi", bus.hi, 32'd0);
    chk("rmid_late_lo", bus.lo, 32'd0);

    repeat (3000) begin
      reset     = ($urandom_range(0, 199) == 0);
      bus.start = 1'($urandom_range(0, 1));
      bus.op    = 3'($urandom_range(0, 7));
      bus.flush = ($urandom_range(0, 7) == 0);
      bus.rs    = pick();
      bus.rt    = pick();
      @(posedge clk); #1;
    end
    reset = 1'b0; bus.start = 1'b0; bus.flush = 1'b0;
    idle(DL + 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
